// File: rtl/sdm_cic_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdm_cic_rx : 1-bit PDM/sigma-delta receiver with 2nd-order CIC decimator |
// | Optional macro SDM_CIC_RX_OVERRUN_EN adds the sticky overrun flag ovr.   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module sdm_cic_rx #(
  parameter int DMSB = 3,
  parameter int RLOG = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            setn,
  input  logic            fclk,
  input  logic            rx,
  input  logic            pop,
  input  logic            clear,
  output logic            full,
  output logic [DMSB:0]   rdata,
  output logic            xst,
  output logic [1:0]      cst,
  output logic [1:0]      nst
`ifdef SDM_CIC_RX_OVERRUN_EN
  ,
  output logic            ovr
`endif
);

  localparam int c_w  = 2 * RLOG + 2;
  localparam int c_sh = 2 * RLOG - DMSB;
  localparam logic signed [c_w-1:0] c_sat_hi = c_w'((1 << DMSB) - 1);
  localparam logic signed [c_w-1:0] c_sat_lo = ~c_sat_hi;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t                r_cst, w_nst;
  logic                  r_fclk_s1, r_fclk_s2, r_fclk_d;
  logic                  r_rx_s1, r_rx_s2;
  logic                  r_pop_d, r_warm, r_full;
  logic [DMSB:0]         r_rdata;
  logic [RLOG-1:0]       r_cnt;
  logic signed [c_w-1:0] r_i1, r_i2, r_i2_d, r_c1_d;
  logic signed [c_w-1:0] w_step, w_i2_nxt, w_c1, w_y, w_ysh;
  logic [DMSB:0]         w_sat;
  logic                  w_stb, w_flush, w_word, w_pop_ev;

  assign w_stb    = r_fclk_s2 & ~r_fclk_d;
  // IDLE also flushes so the first sample counted is the first one seen in SYNC
  assign w_flush  = ~setn | clear | (r_cst == S_IDLE);
  assign w_word   = w_stb & ~w_flush & (&r_cnt);
  assign w_pop_ev = pop ^ r_pop_d;

  assign w_step   = r_rx_s2 ? {{(c_w-1){1'b0}}, 1'b1} : {c_w{1'b1}};
  assign w_i2_nxt = r_i2 + r_i1;
  assign w_c1     = w_i2_nxt - r_i2_d;
  assign w_y      = w_c1 - r_c1_d;
  assign w_ysh    = w_y >>> c_sh;

  always_comb begin
    w_sat = w_ysh[DMSB:0];
    if (w_ysh > c_sat_hi)      w_sat = {1'b0, {DMSB{1'b1}}};
    else if (w_ysh < c_sat_lo) w_sat = {1'b1, {DMSB{1'b0}}};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fclk_s1 <= 1'b0;
      r_fclk_s2 <= 1'b0;
      r_fclk_d  <= 1'b0;
      r_rx_s1   <= 1'b0;
      r_rx_s2   <= 1'b0;
    end else begin
      r_fclk_s1 <= fclk;
      r_fclk_s2 <= r_fclk_s1;
      r_fclk_d  <= r_fclk_s2;
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cst <= S_IDLE;
    else       r_cst <= w_nst;
  end

  always_comb begin
    w_nst = r_cst;
    if (!setn) begin
      w_nst = S_IDLE;
    end else if (clear) begin
      w_nst = S_SYNC;
    end else begin
      case (r_cst)
        S_IDLE:  w_nst = S_SYNC;
        S_SYNC:  if (w_word && r_warm) w_nst = S_RUN;
        S_RUN:   w_nst = S_RUN;
        default: w_nst = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_i1   <= '0;
      r_i2   <= '0;
      r_i2_d <= '0;
      r_c1_d <= '0;
      r_cnt  <= '0;
      r_warm <= 1'b0;
    end else if (w_flush) begin
      r_i1   <= '0;
      r_i2   <= '0;
      r_i2_d <= '0;
      r_c1_d <= '0;
      r_cnt  <= '0;
      r_warm <= 1'b0;
    end else if (w_stb) begin
      r_i1  <= r_i1 + w_step;
      r_i2  <= w_i2_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (&r_cnt) begin
        r_i2_d <= w_i2_nxt;
        r_c1_d <= w_c1;
        if (r_cst == S_SYNC) r_warm <= 1'b1;
      end
    end
  end

  // A word landing in RUN beats a simultaneous pop event
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pop_d <= 1'b0;
      r_full  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_pop_d <= pop;
      if (w_flush) begin
        r_full <= 1'b0;
      end else if (w_word && (r_cst == S_RUN)) begin
        r_full  <= 1'b1;
        r_rdata <= w_sat;
      end else if (w_pop_ev) begin
        r_full <= 1'b0;
      end
    end
  end

`ifdef SDM_CIC_RX_OVERRUN_EN
  logic r_ovr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                                    r_ovr <= 1'b0;
    else if (w_flush)                                             r_ovr <= 1'b0;
    else if (w_word && (r_cst == S_RUN) && r_full && !w_pop_ev)   r_ovr <= 1'b1;
  end

  assign ovr = r_ovr;
`endif

  assign full  = r_full;
  assign rdata = r_rdata;
  assign cst   = r_cst;
  assign nst   = w_nst;
  assign xst   = (r_cst == S_RUN);

endmodule
`default_nettype wire
